// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controller_pkg
//  Description : Shared constants and the ENTDAA target state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package controller_pkg;

  // Broadcast address 7'h7E with R/W = 1
  localparam logic [7:0] DaaRsvdByte = 8'hFD;

  typedef logic [3:0] ccc_entdaa_state_e;

  localparam ccc_entdaa_state_e StIdle        = 4'd0;
  localparam ccc_entdaa_state_e StWaitRstart  = 4'd1;
  localparam ccc_entdaa_state_e StRxRsvd      = 4'd2;
  localparam ccc_entdaa_state_e StAckRsvd     = 4'd3;
  localparam ccc_entdaa_state_e StSendPayload = 4'd4;
  localparam ccc_entdaa_state_e StLostArb     = 4'd5;
  localparam ccc_entdaa_state_e StRxAddr      = 4'd6;
  localparam ccc_entdaa_state_e StAckAddr     = 4'd7;
  localparam ccc_entdaa_state_e StNackAddr    = 4'd8;
  localparam ccc_entdaa_state_e StAssigned    = 4'd9;
  localparam ccc_entdaa_state_e StError       = 4'd10;

endpackage
`default_nettype wire

// File: rtl/i3c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i3c_pkg
//  Description : Generic I3C bus helpers shared across controller blocks.
//                odd_parity() returns 1 when the byte has an odd number of
//                ones (the T-bit convention used on dynamic-address bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
package i3c_pkg;

  function automatic logic odd_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/daa_payload_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : daa_payload_shifter
//  Description : Holds the ENTDAA ID payload and a down-counter that selects
//                the bit currently on the bus (MSB first).
//  Ports       : clk_i, rst_i         - clock, sync active-high reset
//                load_payload_i       - capture payload_i
//                payload_i            - ID payload
//                load_count_i         - preset counter to PayloadWidth-1
//                dec_i                - step to the next lower bit
//                bit_o                - payload bit selected by the counter
//                last_o               - counter is at bit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module daa_payload_shifter #(
  parameter int PayloadWidth = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_payload_i,
  input  logic [PayloadWidth-1:0] payload_i,
  input  logic                    load_count_i,
  input  logic                    dec_i,
  output logic                    bit_o,
  output logic                    last_o
);

  localparam int CntW = (PayloadWidth > 1) ? $clog2(PayloadWidth) : 1;

  logic [PayloadWidth-1:0] payload_q, payload_d;
  logic [CntW-1:0]         count_q, count_d;

  always_comb begin
    payload_d = payload_q;
    count_d   = count_q;
    if (load_payload_i) begin
      payload_d = payload_i;
    end
    if (load_count_i) begin
      count_d = CntW'(PayloadWidth - 1);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      payload_q <= '0;
      count_q   <= '0;
    end else begin
      payload_q <= payload_d;
      count_q   <= count_d;
    end
  end

  assign bit_o  = payload_q[count_q];
  assign last_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ccc_entdaa_target.sv
`default_nettype none
// ============================================================================
//  Module      : ccc_entdaa_target
//  Description : Target-side ENTDAA handler. ACKs the 7E/R header, sends the
//                provisional ID under open-drain arbitration, retries after a
//                loss on the next Sr, then receives, parity-checks and latches
//                the dynamic address.
//  Ports       : clk_i/rst_i                      - clock, sync reset
//                payload_i, start_daa_i           - ID payload, ENTDAA pulse
//                done_daa_o                       - pulse on return to idle
//                bus_rx_*                         - byte receiver handshake
//                bus_tx_*                         - bit transmitter handshake
//                bus_rstart_det_i, bus_stop_det_i - Sr / P detectors
//                arbitration_lost_i               - qualifies bus_tx_done_i
//                address_o, address_valid_o       - assigned dynamic address
//                attempts_o                       - arbitration losses so far
//  Revision    : 1.0 - initial release
// ============================================================================
module ccc_entdaa_target
  import controller_pkg::*;
  import i3c_pkg::*;
#(
  parameter int PayloadWidth = 64,
  parameter int MaxAttempts  = 15,
  parameter bit ParityCheck  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PayloadWidth-1:0] payload_i,
  input  logic                    start_daa_i,
  output logic                    done_daa_o,
  input  logic [7:0]              bus_rx_data_i,
  input  logic                    bus_rx_done_i,
  output logic                    bus_rx_req_bit_o,
  output logic                    bus_rx_req_byte_o,
  input  logic                    bus_tx_done_i,
  output logic                    bus_tx_req_byte_o,
  output logic                    bus_tx_req_bit_o,
  output logic [7:0]              bus_tx_req_value_o,
  output logic                    bus_tx_sel_od_pp_o,
  input  logic                    bus_rstart_det_i,
  input  logic                    bus_stop_det_i,
  input  logic                    arbitration_lost_i,
  output logic [7:0]              address_o,
  output logic                    address_valid_o,
  output logic [3:0]              attempts_o
);

  ccc_entdaa_state_e state_q, state_d;
  logic [3:0] attempts_q, attempts_d;
  logic [6:0] addr_rx_q, addr_rx_d;
  logic [6:0] address_q, address_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;

  logic load_payload, load_count, dec_count;
  logic cur_bit, last_bit;
  logic parity_ok;

  daa_payload_shifter #(
    .PayloadWidth (PayloadWidth)
  ) u_shifter (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .load_payload_i (load_payload),
    .payload_i      (payload_i),
    .load_count_i   (load_count),
    .dec_i          (dec_count),
    .bit_o          (cur_bit),
    .last_o         (last_bit)
  );

  assign parity_ok = !ParityCheck || odd_parity(bus_rx_data_i);

  always_comb begin
    state_d      = state_q;
    attempts_d   = attempts_q;
    addr_rx_d    = addr_rx_q;
    address_d    = address_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    load_payload = 1'b0;
    load_count   = 1'b0;
    dec_count    = 1'b0;

    // Stop wins over any other event; it is meaningless while idle.
    if ((state_q != StIdle) && bus_stop_det_i) begin
      state_d = StIdle;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_daa_i) begin
            state_d      = StWaitRstart;
            load_payload = 1'b1;
            attempts_d   = 4'd0;
            valid_d      = 1'b0;
            address_d    = 7'd0;
          end
        end
        StWaitRstart: begin
          if (bus_rstart_det_i) state_d = StRxRsvd;
        end
        StRxRsvd: begin
          // A wrong header is not NACKed: the target simply stays off the bus.
          if (bus_rx_done_i) begin
            state_d = (bus_rx_data_i == DaaRsvdByte) ? StAckRsvd : StError;
          end
        end
        StAckRsvd: begin
          if (bus_tx_done_i) begin
            load_count = 1'b1;
            state_d    = StSendPayload;
          end
        end
        StSendPayload: begin
          if (bus_tx_done_i) begin
            if (arbitration_lost_i) begin
              state_d = StLostArb;
              if (attempts_q != 4'hF) attempts_d = attempts_q + 4'd1;
            end else if (last_bit) begin
              state_d = StRxAddr;
            end else begin
              dec_count = 1'b1;
            end
          end
        end
        StLostArb: begin
          if (bus_rstart_det_i) begin
            state_d = (32'(attempts_q) < MaxAttempts) ? StRxRsvd : StError;
          end
        end
        StRxAddr: begin
          if (bus_rx_done_i) begin
            addr_rx_d = bus_rx_data_i[7:1];
            state_d   = parity_ok ? StAckAddr : StNackAddr;
          end
        end
        StAckAddr: begin
          if (bus_tx_done_i) begin
            address_d = addr_rx_q;
            valid_d   = 1'b1;
            state_d   = StAssigned;
          end
        end
        StNackAddr: begin
          if (bus_tx_done_i) state_d = StWaitRstart;
        end
        default: ;  // Assigned / Error: wait for Stop
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      attempts_q <= 4'd0;
      addr_rx_q  <= 7'd0;
      address_q  <= 7'd0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      attempts_q <= attempts_d;
      addr_rx_q  <= addr_rx_d;
      address_q  <= address_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // Requests are pure state decodes, so they drop the cycle after the done
  // that moves the FSM on.
  always_comb begin
    bus_rx_req_byte_o = 1'b0;
    bus_tx_req_bit_o  = 1'b0;
    bus_tx_req_value_o = 8'h00;
    case (state_q)
      StRxRsvd, StRxAddr: bus_rx_req_byte_o = 1'b1;
      StAckRsvd, StAckAddr: bus_tx_req_bit_o = 1'b1;
      StSendPayload: begin
        bus_tx_req_bit_o      = 1'b1;
        bus_tx_req_value_o[0] = cur_bit;
      end
      StNackAddr: begin
        bus_tx_req_bit_o      = 1'b1;
        bus_tx_req_value_o[0] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_rx_req_bit_o   = 1'b0;
  assign bus_tx_req_byte_o  = 1'b0;
  assign bus_tx_sel_od_pp_o = 1'b0;
  assign done_daa_o         = done_q;
  assign address_o          = {1'b0, address_q};
  assign address_valid_o    = valid_q;
  assign attempts_o         = attempts_q;

endmodule
`default_nettype wire

// File: doc/ccc_entdaa_target.md
# ccc_entdaa_target

Target-side handler for the ENTDAA (Enter Dynamic Address Assignment) CCC in the I3C controller path. Each round it:
- acknowledges the broadcast 7E/R header;
- shifts out a parametrised provisional-ID payload bit by bit under open-drain arbitration;
- on arbitration loss, retries at the next repeated START;
- on a win, receives and parity-checks the dynamic address and latches it.

It sits between the CCC decoder (which issues `start_daa_i`) and the bus RX/TX/monitor primitives.

## Interface
Parameters:
- `PayloadWidth`, 64 — payload bits sent per round (default: PID 48 + BCR 8 + DCR 8); legal range 8..64.
- `MaxAttempts`, 15 — arbitration losses tolerated before the block gives up for the current ENTDAA.
- `ParityCheck`, 1 — 1: check odd parity on the received address; 0: ignore the parity bit.

Ports:
- `clk_i` in 1 — sole clock.
- `rst_i` in 1 — reset, synchronous, active-high.
- `payload_i` in PayloadWidth — ID payload, sent MSB first; sampled on `start_daa_i`.
- `start_daa_i` in 1 — 1-cycle pulse: ENTDAA decoded.
- `done_daa_o` out 1 — 1-cycle pulse on exit to Idle.
- `bus_rx_data_i` in 8 — received byte.
- `bus_rx_done_i` in 1 — RX byte complete.
- `bus_rx_req_bit_o` out 1 — tied 0.
- `bus_rx_req_byte_o` out 1 — request byte reception.
- `bus_tx_done_i` in 1 — TX bit complete.
- `bus_tx_req_byte_o` out 1 — tied 0.
- `bus_tx_req_bit_o` out 1 — request TX of one bit.
- `bus_tx_req_value_o` out 8 — bit 0 carries the value; bits 7:1 are 0.
- `bus_tx_sel_od_pp_o` out 1 — always 0 (open-drain throughout DAA).
- `bus_rstart_det_i` in 1 — Sr detected.
- `bus_stop_det_i` in 1 — P detected.
- `arbitration_lost_i` in 1 — valid with `bus_tx_done_i`.
- `address_o` out 8 — {1'b0, dynamic address[6:0]}.
- `address_valid_o` out 1 — the address is assigned.
- `attempts_o` out 4 — arbitration losses in the current ENTDAA.

## Operation
States: Idle, WaitRstart, RxRsvd, AckRsvd, SendPayload, LostArb, RxAddr, AckAddr, NackAddr, Assigned, Error.

Transitions:
- Idle → WaitRstart on `start_daa_i`. The same cycle latches `payload_i` into a shift register, clears `attempts_o` and clears `address_valid_o`.
- WaitRstart → RxRsvd on `bus_rstart_det_i`.
- RxRsvd (`bus_rx_req_byte_o`=1):
  - on `bus_rx_done_i`, data == 8'hFD (7E, R=1) → AckRsvd;
  - any other byte → Error. No NACK is driven; the target stays off the bus.
- AckRsvd: TX bit value 0. On `bus_tx_done_i`, load the bit counter with `PayloadWidth`-1 → SendPayload.
- SendPayload: TX bit = payload[counter]. On `bus_tx_done_i`:
  - `arbitration_lost_i`=1 → LostArb;
  - else counter==0 → RxAddr;
  - else decrement the counter.
- LostArb: increment `attempts_o` (saturating at 15). On `bus_rstart_det_i`:
  - `attempts_o` < `MaxAttempts` → RxRsvd;
  - otherwise → Error.
- RxAddr: on `bus_rx_done_i`, address = data[7:1], parity = data[0].
  - Parity is OK when ^data[7:0] == 1 (odd), or always when `ParityCheck`=0.
  - OK → AckAddr; otherwise → NackAddr.
- AckAddr: TX bit 0. On `bus_tx_done_i`, latch `address_o` and set `address_valid_o` → Assigned.
- NackAddr: TX bit 1. On `bus_tx_done_i` → WaitRstart. The target re-competes in the next round.
- Assigned and Error: drive nothing; wait for Stop.

Global rules:
- `bus_stop_det_i` in any non-Idle state → Idle next cycle, with `done_daa_o`=1 that cycle. Stop has priority over every other event in the same cycle.
- In Idle, Stop is ignored.
- `start_daa_i` outside Idle is ignored.
- `address_valid_o` and `address_o` persist through Stop. They clear only on `rst_i` or on a new `start_daa_i`.

## Timing
- All outputs are registered or decoded from `state_q`. Request outputs are asserted from the first cycle in a state and held until the matching done is sampled; they drop the cycle after.
- Done and `arbitration_lost_i` are sampled only in states that request them; strays are ignored.
- `rst_i` (at any time, including mid-payload) forces, on the next edge:
  - state to Idle, counter to 0, `attempts_o` to 0;
  - `address_o` to 0, `address_valid_o` to 0, `done_daa_o` to 0;
  - all bus request outputs to 0.
- Latency: Sr → `bus_rx_req_byte_o` is 1 cycle. The final ACK `bus_tx_done_i` → `address_valid_o` is 1 cycle.
- Minimum round: 1 (ACK) + `PayloadWidth` + 1 (ACK) TX bit transactions.

## Structure
- `ccc_entdaa_state_e` and the constant `DaaRsvdByte` = 8'hFD go in `controller_pkg`.
- The odd-parity helper function goes in `i3c_pkg`.
- One sub-module, `daa_payload_shifter`: loadable `PayloadWidth` register plus down-counter. Outputs the current bit and a last-bit flag.

## Test plan
- Win path: payload 64'h0123_4567_89AB_CDEF, rx 8'hFD, 64 TX bits with no loss, rx 8'h10 (addr 7'h08, odd) → ACK, `address_o`=8'h08, `address_valid_o`=1; Stop → `done_daa_o` pulse.
- Bad parity: rx 8'h11 → NACK (bit 1), then WaitRstart; next round succeeds with 8'h10.
- Arbitration loss at bit 5, then Sr, 8'hFD, win → `attempts_o`=1, address assigned.
- `MaxAttempts`=2, lose twice → Error; Stop → `done_daa_o`, `address_valid_o`=0.
- Header 8'hFC → no TX request, Error until Stop; simultaneous Stop and `bus_tx_done_i` → Idle.
- `rst_i` mid-payload → next cycle all outputs 0, state Idle; `PayloadWidth`=8 run sends exactly 8 bits.
